evrisim_denetleyici: RTL and testbench

EVRISIM_DENETLEYICI -- requirements
Module: evrisim_denetleyici

---
 rtl/evrisim_denetleyici_if.sv | 44 ++++
 rtl/evrisim_denetleyici.sv | 145 ++++++++++++++
 tb/tb_evrisim_denetleyici.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/evrisim_denetleyici_if.sv
// Job, pixel and convolution-side signal bundle of evrisim_denetleyici.
// EVRISIM_DENETLEYICI_IPTAL_EN adds the abort request/status pair.
interface evrisim_denetleyici_if;
  logic        is_gecerli_i;
  logic        is_hazir_o;
  logic [1:0]  is_tur_i;
  logic [71:0] is_filtre_i;
  logic        piksel_gecerli_i;
  logic [7:0]  piksel_i;
  logic        piksel_hazir_o;
  logic        filtre_etkin_o;
  logic [71:0] filtre_o;
  logic        gaus_o;
  logic        laplacian_o;
  logic        gr2bw_erosion_o;
  logic        veri_etkin_o;
  logic [7:0]  veri_o;
  logic        mesgul_o;
  logic        bitti_o;
`ifdef EVRISIM_DENETLEYICI_IPTAL_EN
  logic        iptal_i;
  logic        iptal_edildi_o;
`endif

  modport master (
`ifdef EVRISIM_DENETLEYICI_IPTAL_EN
    output iptal_i,
    input  iptal_edildi_o,
`endif
    output is_gecerli_i, is_tur_i, is_filtre_i, piksel_gecerli_i, piksel_i,
    input  is_hazir_o, piksel_hazir_o, filtre_etkin_o, filtre_o, gaus_o,
           laplacian_o, gr2bw_erosion_o, veri_etkin_o, veri_o, mesgul_o, bitti_o
  );

  modport slave (
`ifdef EVRISIM_DENETLEYICI_IPTAL_EN
    input  iptal_i,
    output iptal_edildi_o,
`endif
    input  is_gecerli_i, is_tur_i, is_filtre_i, piksel_gecerli_i, piksel_i,
    output is_hazir_o, piksel_hazir_o, filtre_etkin_o, filtre_o, gaus_o,
           laplacian_o, gr2bw_erosion_o, veri_etkin_o, veri_o, mesgul_o, bitti_o
  );
endinterface

// File: rtl/evrisim_denetleyici.sv
// Job controller feeding one frame of pixels plus a row flush to a convolution unit.
// Optional abort support is enabled by defining EVRISIM_DENETLEYICI_IPTAL_EN.
module evrisim_denetleyici #(
  parameter int unsigned GENISLIK  = 320,
  parameter int unsigned YUKSEKLIK = 240
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  evrisim_denetleyici_if.slave bus
);

  localparam logic [16:0] SON_PIKSEL = 17'(GENISLIK * YUKSEKLIK - 1);
  localparam logic [8:0]  SON_BOSALT = 9'(GENISLIK);

  typedef enum logic [2:0] {BOSTA, FILTRE_YUKLE, AKIS, BOSALT, BITTI} durum_t;

  durum_t      durum_q, durum_d;
  logic [1:0]  tur_q, tur_d;
  logic [71:0] filtre_q, filtre_d;
  logic [16:0] piksel_say_q, piksel_say_d;
  logic [8:0]  bosalt_say_q, bosalt_say_d;
  logic [7:0]  veri_q;
  logic        iptal_q, iptal_d;
  logic        iptal_istek;

  logic        is_hazir;
  logic        piksel_hazir;
  logic        filtre_etkin;
  logic        veri_etkin;
  logic [7:0]  veri;
  logic        bitti;
  logic        son_piksel;

`ifdef EVRISIM_DENETLEYICI_IPTAL_EN
  assign iptal_istek        = bus.iptal_i;
  assign bus.iptal_edildi_o = bitti & iptal_q;
`else
  assign iptal_istek = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q      <= BOSTA;
      tur_q        <= '0;
      filtre_q     <= '0;
      piksel_say_q <= '0;
      bosalt_say_q <= '0;
      veri_q       <= '0;
      iptal_q      <= 1'b0;
    end else begin
      durum_q      <= durum_d;
      tur_q        <= tur_d;
      filtre_q     <= filtre_d;
      piksel_say_q <= piksel_say_d;
      bosalt_say_q <= bosalt_say_d;
      veri_q       <= veri;
      iptal_q      <= iptal_d;
    end
  end

  always_comb begin
    durum_d      = durum_q;
    tur_d        = tur_q;
    filtre_d     = filtre_q;
    piksel_say_d = piksel_say_q;
    bosalt_say_d = bosalt_say_q;
    iptal_d      = iptal_q;
    is_hazir     = 1'b0;
    piksel_hazir = 1'b0;
    filtre_etkin = 1'b0;
    veri_etkin   = 1'b0;
    veri         = veri_q;
    bitti        = 1'b0;
    son_piksel   = (piksel_say_q == SON_PIKSEL);

    unique case (durum_q)
      BOSTA: begin
        is_hazir = 1'b1;
        if (bus.is_gecerli_i) begin
          tur_d        = bus.is_tur_i;
          filtre_d     = bus.is_filtre_i;
          iptal_d      = 1'b0;
          piksel_say_d = '0;
          bosalt_say_d = '0;
          durum_d      = FILTRE_YUKLE;
        end
      end

      FILTRE_YUKLE: begin
        filtre_etkin = 1'b1;
        durum_d      = AKIS;
      end

      AKIS: begin
        piksel_hazir = ~iptal_q;
        // After an abort the remaining frame is padded with zero pixels so the
        // convolution unit still sees a complete frame.
        if (iptal_q) begin
          veri_etkin = 1'b1;
          veri       = '0;
        end else if (bus.piksel_gecerli_i) begin
          veri_etkin = 1'b1;
          veri       = bus.piksel_i;
        end
        if (veri_etkin) begin
          piksel_say_d = son_piksel ? '0 : piksel_say_q + 17'd1;
        end
        if (veri_etkin && son_piksel) begin
          durum_d = BOSALT;
        end else if (iptal_istek) begin
          iptal_d = 1'b1;
        end
      end

      BOSALT: begin
        if (bosalt_say_q == SON_BOSALT) begin
          bosalt_say_d = '0;
          durum_d      = BITTI;
        end else begin
          bosalt_say_d = bosalt_say_q + 9'd1;
        end
      end

      BITTI: begin
        bitti   = 1'b1;
        durum_d = BOSTA;
      end

      default: durum_d = BOSTA;
    endcase
  end

  assign bus.is_hazir_o      = is_hazir;
  assign bus.piksel_hazir_o  = piksel_hazir;
  assign bus.filtre_etkin_o  = filtre_etkin;
  assign bus.filtre_o        = filtre_q;
  assign bus.gaus_o          = (tur_q == 2'b01);
  assign bus.laplacian_o     = (tur_q == 2'b10);
  assign bus.gr2bw_erosion_o = (tur_q == 2'b11);
  assign bus.veri_etkin_o    = veri_etkin;
  assign bus.veri_o          = veri;
  assign bus.mesgul_o        = (durum_q != BOSTA);
  assign bus.bitti_o         = bitti;

endmodule

// File: tb/tb_evrisim_denetleyici.sv
// Self-checking bench for evrisim_denetleyici on a reduced 8x4 frame.
// Define EVRISIM_DENETLEYICI_IPTAL_EN to also exercise the abort path.
module tb_evrisim_denetleyici;

  localparam int unsigned W = 8;
  localparam int unsigned H = 4;
  localparam int          N = W * H;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  evrisim_denetleyici_if bus ();

  evrisim_denetleyici #(.GENISLIK(W), .YUKSEKLIK(H)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  tur;
    logic [71:0] filt;
    logic [2:0]  mod;      // expected {gaus, laplacian, erosion}
    int          gap;      // 0 continuous, 1 every third cycle, 2 random
    int          rst_at;   // pixel index at which reset is pulsed, -1 none
    int          iptal_at; // pixel index at which abort is requested, -1 none
    bit          sonraki;  // next job's request is raised during BITTI
  } vec_t;

  int n_test = 0;
  int n_fail = 0;

  logic [7:0]  son_veri;
  logic [71:0] bek_filtre;
  logic [2:0]  bek_mod;

  task automatic chk1(input string ad, input logic gercek, input logic beklenen);
    n_test++;
    if (gercek !== beklenen) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  task automatic chk72(input string ad, input logic [71:0] gercek, input logic [71:0] beklenen);
    n_test++;
    if (gercek !== beklenen) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  task automatic chk_mod(input string ad);
    chk72({ad, ".filtre"}, bus.filtre_o, bek_filtre);
    chk72({ad, ".mod"}, 72'({bus.gaus_o, bus.laplacian_o, bus.gr2bw_erosion_o}), 72'(bek_mod));
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bosta(input string ad);
    chk1({ad, ".mesgul"}, bus.mesgul_o, 1'b0);
    chk1({ad, ".is_hazir"}, bus.is_hazir_o, 1'b1);
    chk1({ad, ".bitti"}, bus.bitti_o, 1'b0);
    chk1({ad, ".filtre_etkin"}, bus.filtre_etkin_o, 1'b0);
    chk1({ad, ".piksel_hazir"}, bus.piksel_hazir_o, 1'b0);
    chk1({ad, ".veri_etkin"}, bus.veri_etkin_o, 1'b0);
  endtask

  task automatic run_job(input vec_t v, input logic [1:0] s_tur, input logic [71:0] s_filt);
    int         k = 0;
    int         bekle = 0;
    bit         iptal = 1'b0;
    bit         gec;
    bit         yi;
    logic [7:0] pix;

    // Request in BOSTA; previous configuration must still be on the outputs.
    bus.is_gecerli_i = 1'b1;
    bus.is_tur_i     = v.tur;
    bus.is_filtre_i  = v.filt;
    sample();
    chk_bosta("bosta");
    chk_mod("bosta");
    advance();
    bus.is_gecerli_i = 1'b0;
    bus.is_tur_i     = 2'($urandom());
    bus.is_filtre_i  = 72'({$urandom(), $urandom(), $urandom()});
    bek_filtre = v.filt;
    bek_mod    = v.mod;

    sample();
    chk1("yukle.filtre_etkin", bus.filtre_etkin_o, 1'b1);
    chk1("yukle.is_hazir", bus.is_hazir_o, 1'b0);
    chk1("yukle.mesgul", bus.mesgul_o, 1'b1);
    chk1("yukle.piksel_hazir", bus.piksel_hazir_o, 1'b0);
    chk_mod("yukle");
    advance();

    while (k < N) begin
      if (bekle > 20 * N) begin
        n_test++;
        n_fail++;
        $display("FAIL akis.timeout: got %0d pixels expected %0d", k, N);
        return;
      end
      bekle++;
      if (k == v.rst_at) begin
        rst = 1'b1;
        bus.piksel_gecerli_i = 1'b1;
        advance();
        rst = 1'b0;
        bus.piksel_gecerli_i = 1'b0;
        bek_filtre = '0;
        bek_mod    = '0;
        son_veri   = '0;
        sample();
        chk_bosta("rst_orta");
        chk_mod("rst_orta");
        chk72("rst_orta.veri", 72'(bus.veri_o), 72'(son_veri));
        for (int c = 0; c < int'(W) + 3; c++) begin
          advance();
          sample();
          chk1("rst_orta.bitti_yok", bus.bitti_o, 1'b0);
          chk1("rst_orta.mesgul_yok", bus.mesgul_o, 1'b0);
        end
        advance();
        return;
      end
      case (v.gap)
        0:       gec = 1'b1;
        1:       gec = (bekle % 3 == 0);
        default: gec = 1'($urandom());
      endcase
      yi = (!iptal && k == v.iptal_at);
      if (yi) gec = 1'b0;
      pix = 8'($urandom());
      bus.piksel_gecerli_i = gec;
      bus.piksel_i         = pix;
`ifdef EVRISIM_DENETLEYICI_IPTAL_EN
      bus.iptal_i = yi;
`endif
      sample();
      chk1("akis.mesgul", bus.mesgul_o, 1'b1);
      chk1("akis.filtre_etkin", bus.filtre_etkin_o, 1'b0);
      chk_mod("akis");
      if (iptal) begin
        chk1("iptal.piksel_hazir", bus.piksel_hazir_o, 1'b0);
        chk1("iptal.veri_etkin", bus.veri_etkin_o, 1'b1);
        chk72("iptal.veri", 72'(bus.veri_o), 72'h0);
        son_veri = '0;
        k++;
      end else begin
        chk1("akis.piksel_hazir", bus.piksel_hazir_o, 1'b1);
        chk1("akis.veri_etkin", bus.veri_etkin_o, gec);
        if (gec) begin
          chk72("akis.veri", 72'(bus.veri_o), 72'(pix));
          son_veri = pix;
          k++;
        end else begin
          chk72("akis.veri_tut", 72'(bus.veri_o), 72'(son_veri));
        end
      end
      if (yi) iptal = 1'b1;
      advance();
    end

    // Flush: exactly W+1 quiet cycles after the last pixel.
    for (int c = 0; c < int'(W) + 1; c++) begin
      bus.piksel_gecerli_i = 1'($urandom());
`ifdef EVRISIM_DENETLEYICI_IPTAL_EN
      bus.iptal_i = 1'($urandom());
`endif
      sample();
      chk1("bosalt.bitti", bus.bitti_o, 1'b0);
      chk1("bosalt.piksel_hazir", bus.piksel_hazir_o, 1'b0);
      chk1("bosalt.veri_etkin", bus.veri_etkin_o, 1'b0);
      chk1("bosalt.mesgul", bus.mesgul_o, 1'b1);
      chk72("bosalt.veri", 72'(bus.veri_o), 72'(son_veri));
      advance();
    end

    bus.piksel_gecerli_i = 1'b0;
`ifdef EVRISIM_DENETLEYICI_IPTAL_EN
    bus.iptal_i = 1'b0;
`endif
    if (v.sonraki) begin
      bus.is_gecerli_i = 1'b1;
      bus.is_tur_i     = s_tur;
      bus.is_filtre_i  = s_filt;
    end
    sample();
    chk1("bitti.bitti", bus.bitti_o, 1'b1);
    chk1("bitti.mesgul", bus.mesgul_o, 1'b1);
    chk1("bitti.is_hazir", bus.is_hazir_o, 1'b0);
    chk1("bitti.filtre_etkin", bus.filtre_etkin_o, 1'b0);
`ifdef EVRISIM_DENETLEYICI_IPTAL_EN
    chk1("bitti.iptal_edildi", bus.iptal_edildi_o, iptal);
`endif
    chk_mod("bitti");
    advance();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v[9];
    int   n_vec;

    v[0] = '{2'b01, 72'h010201020402010201, 3'b100, 0, -1, -1, 1'b0};
    v[1] = '{2'b10, 72'hFFFFFFFF08FFFFFFFF, 3'b010, 1, -1, -1, 1'b0};
    v[2] = '{2'b00, 72'h123456789ABCDEF012, 3'b000, 2, -1, -1, 1'b1};
    v[3] = '{2'b11, 72'h000000000100000000, 3'b001, 2, -1, -1, 1'b0};
    v[4] = '{2'b10, 72'h80706050403020100F, 3'b010, 0, N / 2, -1, 1'b0};
    v[5] = '{2'b01, 72'h7F7F7F7F7F7F7F7F7F, 3'b100, 2, -1, -1, 1'b0};
    v[6] = '{2'b10, 72'h0102030405060708F9, 3'b010, 0, -1, N / 4, 1'b0};
    v[7] = '{2'b11, 72'hA5A5A5A5A5A5A5A5A5, 3'b001, 2, -1, -1, 1'b0};
    v[8] = '{2'b00, 72'h0, 3'b000, 0, -1, -1, 1'b0};
`ifdef EVRISIM_DENETLEYICI_IPTAL_EN
    n_vec = 8;
    bus.iptal_i = 1'b0;
`else
    n_vec = 6;
`endif

    rst                  = 1'b1;
    bus.is_gecerli_i     = 1'b0;
    bus.is_tur_i         = '0;
    bus.is_filtre_i      = '0;
    bus.piksel_gecerli_i = 1'b0;
    bus.piksel_i         = '0;
    son_veri             = '0;
    bek_filtre           = '0;
    bek_mod              = '0;

    advance();
    advance();
    sample();
    chk_bosta("reset");
    chk_mod("reset");
    chk72("reset.veri", 72'(bus.veri_o), 72'h0);
    rst = 1'b0;
    advance();

    for (int i = 0; i < n_vec; i++) begin
      run_job(v[i], v[i + 1].tur, v[i + 1].filt);
    end

    sample();
    chk_bosta("son");
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
